// File: rtl/adc_capture_mc_pkg.sv
// Shared definitions for the multi-channel ADC capture block: FSM encoding,
// stored-word layout and the channel-count ceiling.
package adc_capture_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_CAPT = 2'd2,
    ST_FIN  = 2'd3
  } cap_state_t;

  localparam int WORD_W  = 16;
  localparam int OTR_BIT = 15;
  localparam int MAX_CH  = 8;

  // A programmed divider of 0 would give no distinct low phase, so it runs as 1.
  function automatic logic [31:0] eff_div(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/adc_capture_mc_div.sv
// Sampling-clock divider: counts 0..d, high for 0..d/2, with rise/fall pulses.
// Held at d while stopped; restart forces count 0 so the first rise is immediate.
module adc_cap_div #(
  parameter int DIV_W = 11
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run,
  input  logic             restart,
  input  logic [DIV_W-1:0] d,
  output logic             adc_clk,
  output logic             rise,
  output logic             fall
);

  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] half;

  assign half = d >> 1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_reg <= '0;
    end else if (restart) begin
      cnt_reg <= '0;
    end else if (!run) begin
      cnt_reg <= d;
    end else if (cnt_reg >= d) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + DIV_W'(1);
    end
  end

  assign adc_clk = run && (cnt_reg <= half);
  assign rise    = run && (cnt_reg == '0);
  assign fall    = run && (cnt_reg == half + DIV_W'(1));

endmodule

// File: rtl/adc_capture_mc.sv
// Multi-channel ADC capture into per-channel buffers with one-cycle readback.
// Optional build macro ADC_CAP_OTR_TAG_EN stores each sample's OTR flag in bit 15.
module adc_capture_mc
  import adc_capture_mc_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int ADC_W = 12,
  parameter int AW    = 11,
  parameter int DIV_W = 11
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [DIV_W-1:0]     DIVIDER,
  input  logic [AW-1:0]        NSAMP,
  input  logic [NCH*ADC_W-1:0] ADC_BIT,
  input  logic [NCH-1:0]       ADC_OTR,
  output logic                 ADC_CLK,
  output logic                 ADC_OE,
  input  logic [2:0]           RD_CH,
  input  logic [AW-1:0]        RD_ADDR,
  output logic [WORD_W-1:0]    RD_DATA,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [NCH-1:0]       OVR
);

  cap_state_t           state_reg;
  logic [DIV_W-1:0]     div_reg;
  logic [AW-1:0]        nsamp_reg;
  logic [AW-1:0]        w_reg;
  logic                 pend_reg;
  logic [NCH*ADC_W-1:0] samp_reg;
  logic [2:0]           rd_ch_reg;
  logic                 rd_zero_reg;

  logic [DIV_W-1:0] div_in;
  logic [DIV_W-1:0] div_cur;
  logic             start_go;
  logic             rise;
  logic             fall;
  logic             wr_en;

  assign div_in   = DIV_W'(eff_div(32'(DIVIDER)));
  assign div_cur  = BUSY ? div_reg : div_in;
  assign start_go = (state_reg == ST_IDLE) && START;
  // ABORT on the write cycle drops the pending sample.
  assign wr_en    = (state_reg == ST_CAPT) && rise && pend_reg && !ABORT;

  adc_cap_div #(.DIV_W(DIV_W)) u_div (
    .CLK     (CLK),
    .RST     (RST),
    .run     (BUSY),
    .restart (start_go),
    .d       (div_cur),
    .adc_clk (ADC_CLK),
    .rise    (rise),
    .fall    (fall)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= ST_IDLE;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ADC_OE    <= 1'b1;
      OVR       <= '0;
      w_reg     <= '0;
      pend_reg  <= 1'b0;
      div_reg   <= '0;
      nsamp_reg <= '0;
      samp_reg  <= '0;
    end else begin
      DONE <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (START) begin
            state_reg <= ST_ARM;
            BUSY      <= 1'b1;
            ADC_OE    <= 1'b0;
            OVR       <= '0;
            w_reg     <= '0;
            pend_reg  <= 1'b0;
            div_reg   <= div_in;
            nsamp_reg <= NSAMP;
          end
        end
        ST_ARM: begin
          if (ABORT) begin
            state_reg <= ST_FIN;
            DONE      <= 1'b1;
            ADC_OE    <= 1'b1;
          end else if (rise) begin
            state_reg <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          if (ABORT) begin
            state_reg <= ST_FIN;
            DONE      <= 1'b1;
            ADC_OE    <= 1'b1;
          end else begin
            if (fall) begin
              samp_reg <= ADC_BIT;
              OVR      <= OVR | ADC_OTR;
              pend_reg <= 1'b1;
            end
            if (wr_en) begin
              w_reg    <= w_reg + AW'(1);
              pend_reg <= 1'b0;
              if (w_reg == nsamp_reg) begin
                state_reg <= ST_FIN;
                DONE      <= 1'b1;
                ADC_OE    <= 1'b1;
              end
            end
          end
        end
        ST_FIN: begin
          state_reg <= ST_IDLE;
          BUSY      <= 1'b0;
          ADC_OE    <= 1'b1;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef ADC_CAP_OTR_TAG_EN
  logic [NCH-1:0] otr_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      otr_reg <= '0;
    end else if ((state_reg == ST_CAPT) && fall && !ABORT) begin
      otr_reg <= ADC_OTR;
    end
  end
`endif

  // Unused channel slots read as zero so the select mux needs no range check.
  wire [WORD_W-1:0] rd_q [MAX_CH];

  for (genvar gi = 0; gi < MAX_CH; gi++) begin : g_ch
    if (gi < NCH) begin : g_ram
      logic [WORD_W-1:0] mem [2**AW];
      logic [WORD_W-1:0] q_reg;
      logic [WORD_W-1:0] wr_word;

      always_comb begin
        wr_word = '0;
        wr_word[ADC_W-1:0] = samp_reg[gi*ADC_W +: ADC_W];
`ifdef ADC_CAP_OTR_TAG_EN
        wr_word[OTR_BIT] = otr_reg[gi];
`endif
      end

      always_ff @(posedge CLK) begin
        if (wr_en) begin
          mem[w_reg] <= wr_word;
        end
        q_reg <= mem[RD_ADDR];
      end

      assign rd_q[gi] = q_reg;
    end else begin : g_nil
      assign rd_q[gi] = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_ch_reg   <= '0;
      rd_zero_reg <= 1'b1;
    end else begin
      rd_ch_reg   <= RD_CH;
      rd_zero_reg <= (int'(RD_CH) >= NCH);
    end
  end

  assign RD_DATA = rd_zero_reg ? '0 : rd_q[rd_ch_reg];

endmodule

// File: doc/adc_capture_mc.md
ADC_CAPTURE_MC -- requirements
Module: adc_capture_mc

Interface
REQ-001 Parameter NCH, default 2: number of ADC channels captured in parallel, 1..8.
REQ-002 Parameter ADC_W, default 12: ADC sample width, 8..15.
REQ-003 Parameter AW, default 11: buffer address width; depth per channel is 2^AW.
REQ-004 Parameter DIV_W, default 11: divider field width.
REQ-005 CLK  input  1  system clock; all logic is on its rising edge.
REQ-006 RST  input  1  reset, asynchronous, active-low.
REQ-007 START  input  1  one-cycle capture request; honoured only in IDLE.
REQ-008 ABORT  input  1  terminates an active capture; ignored in IDLE.
REQ-009 DIVIDER  input  DIV_W  ADC_CLK period minus 1, in CLK cycles; sampled at START.
REQ-010 NSAMP  input  AW  number of samples per channel minus 1; sampled at START.
REQ-011 ADC_BIT  input  NCH*ADC_W  ADC data buses; channel c occupies bits [c*ADC_W +: ADC_W].
REQ-012 ADC_OTR  input  NCH  per-channel out-of-range flags.
REQ-013 ADC_CLK  output  1  divided sampling clock driven to the converters.
REQ-014 ADC_OE  output  1  converter output enable, active-low.
REQ-015 RD_CH  input  3  readback channel select.
REQ-016 RD_ADDR  input  AW  readback sample index.
REQ-017 RD_DATA  output  16  readback word.
REQ-018 BUSY  output  1  high in every state except IDLE.
REQ-019 DONE  output  1  one-cycle completion pulse.
REQ-020 OVR  output  NCH  sticky per-channel out-of-range flag for the last capture.

Function
REQ-021 The FSM SHALL have four states: IDLE, ARM, CAPT and FIN.
- IDLE -> ARM on START.
- ARM -> CAPT on the first ADC_CLK rising pulse.
- CAPT -> FIN after sample NSAMP is written, or on ABORT.
- FIN -> IDLE after one cycle.
REQ-022 The divider SHALL count 0..D and wrap, where D = max(DIVIDER, 1).
- ADC_CLK is high for counts 0..floor(D/2) and low otherwise.
- Rise pulse at count 0; fall pulse at count floor(D/2)+1.
REQ-023 The divider SHALL run only while BUSY. It is held at count D in IDLE, so that the first rise pulse occurs one cycle after START.
REQ-024 ADC_OE SHALL be 0 in ARM and CAPT, and 1 in IDLE and FIN.
REQ-025 On each fall pulse in CAPT, all NCH channels SHALL be registered simultaneously.
REQ-026 On the next rise pulse, the registered words SHALL be written at write index W, and W SHALL then increment.
REQ-027 W SHALL reset to 0 at START; the final write is at W = NSAMP. NSAMP = 0 yields exactly one sample per channel.
REQ-028 Stored word format: bits [ADC_W-1:0] = sample, bits [14:ADC_W] = 0, bit 15 per REQ-036/037.
REQ-029 Readback SHALL have a latency of exactly one CLK cycle, from RD_CH/RD_ADDR to RD_DATA, and SHALL be valid in every state.
REQ-030 RD_CH >= NCH SHALL return 16'h0000.
REQ-031 DONE SHALL pulse in FIN whether capture completed or was aborted.
REQ-032 A START received while BUSY SHALL be ignored.
REQ-033 ABORT and START in the same cycle while BUSY: ABORT wins.
REQ-034 OVR SHALL clear at START; bit c is set when ADC_OTR[c] = 1 at a capture fall pulse.
REQ-035 A write in flight on the same cycle as ABORT SHALL be discarded.

Configuration
REQ-036 With ADC_CAP_OTR_TAG_EN defined, bit 15 of each stored word SHALL equal the ADC_OTR bit captured with that sample.
REQ-037 Without ADC_CAP_OTR_TAG_EN, bit 15 SHALL be 0. OVR is unaffected either way.

Reset
REQ-038 On RST low: state = IDLE, ADC_CLK = 0, ADC_OE = 1, BUSY = 0, DONE = 0, OVR = 0, W = 0, RD_DATA = 0.
REQ-039 Reset mid-capture SHALL abort without a DONE pulse. Buffer contents are undefined afterwards.

Structure
REQ-040 A shared package SHALL hold the FSM state encoding, the word-format constants (OTR bit position 15, word width 16) and the maximum-channel constant 8.
REQ-041 The block SHALL contain one sub-module, adc_cap_div: the divider with rise/fall pulse outputs.
REQ-042 Buffers SHALL be inferred simple dual-port RAM, one per channel, generated with a generate loop.

Verification
REQ-043 DIVIDER=4, NSAMP=7, NCH=2, ramp on ch0 and constant 0xABC on ch1:
- ADC_CLK period is 5 cycles.
- BUSY is high for 8 periods plus the ARM/FIN cycles.
- DONE pulses once.
- Readback gives ch0 = ramp values and ch1 = 0xABC at addresses 0..7.
REQ-044 NSAMP=0, DIVIDER=0: divider is treated as 1 (period 2); exactly one write per channel; DONE follows.
REQ-045 ABORT raised after 3 samples, with START asserted in the same cycle: FSM goes FIN -> IDLE; DONE pulses; addresses 0..2 hold data; the START is not honoured.
REQ-046 ADC_OTR[1] pulsed high on sample 5:
- OVR = 2'b10.
- With the macro defined, word 5 of ch1 has bit 15 = 1.
- Without the macro, bit 15 = 0.
REQ-047 RST asserted low mid-capture: all outputs take their reset values immediately; no DONE pulse; a new START then captures normally.
REQ-048 RD_CH = 5 with NCH = 2 returns 0x0000; a read at any address returns data one cycle later.
